// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if
//   Bundles every signal between the EX stage, the shared multiply/divide
//   engines and the HI/LO write port around hilo_muldiv_ctrl.
//   slave  : the sequencer itself (hilo_muldiv_ctrl).
//   master : the environment side (EX stage plus the engines).
//   Request : req_valid, req_op[2:0], req_src1[31:0], req_src2[31:0], flush
//   Pipeline: stallreq, busy
//   Mult    : mul_start, mul_signed, mul_a, mul_b -> ; <- mul_ready, mul_result[63:0]
//   Div     : div_start, div_signed, div_annul, div_a, div_b -> ; <- div_ready, div_result[63:0]
//   HI/LO   : hi_we, hi_wdata, lo_we, lo_wdata
interface hilo_muldiv_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        stallreq;
  logic        busy;
  logic        mul_start;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_ready;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_ready;
  logic [63:0] div_result;
  logic        hi_we;
  logic [31:0] hi_wdata;
  logic        lo_we;
  logic [31:0] lo_wdata;

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush,
    input  mul_ready, mul_result, div_ready, div_result,
    output stallreq, busy,
    output mul_start, mul_signed, mul_a, mul_b,
    output div_start, div_signed, div_annul, div_a, div_b,
    output hi_we, hi_wdata, lo_we, lo_wdata
  );

  modport master (
    output req_valid, req_op, req_src1, req_src2, flush,
    output mul_ready, mul_result, div_ready, div_result,
    input  stallreq, busy,
    input  mul_start, mul_signed, mul_a, mul_b,
    input  div_start, div_signed, div_annul, div_a, div_b,
    input  hi_we, hi_wdata, lo_we, lo_wdata
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Sequencer owning the HI/LO write path of the EX stage. Accepts one
//   HI/LO-class op (MULT, MULTU, DIV, DIVU, MTHI, MTLO) in IDLE, launches the
//   shared multiplier or divider with registered operands, stalls the
//   pipeline until the engine is ready and then writes HI/LO exactly once.
//   MTHI/MTLO write combinationally in the accept cycle; divide-by-zero skips
//   the divider and writes HI=dividend, LO=all ones.
//   Ports:
//     clk : clock
//     rst : synchronous, active-high reset
//     bus : hilo_muldiv_ctrl_if.slave (request, engine and HI/LO signals)
module hilo_muldiv_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  hilo_muldiv_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  state_t      state, state_next;
  logic [31:0] opa_q, opb_q;
  logic        sign_q;
  logic [31:0] res_hi_q, res_lo_q;

  logic        load_ops;
  logic        load_res;
  logic [31:0] res_hi_d, res_lo_d;
  logic        req_signed;

  assign req_signed = (bus.req_op == OP_MULT) || (bus.req_op == OP_DIV);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sign_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state <= state_next;
      if (load_ops) begin
        opa_q  <= bus.req_src1;
        opb_q  <= bus.req_src2;
        sign_q <= req_signed;
      end
      if (load_res) begin
        res_hi_q <= res_hi_d;
        res_lo_q <= res_lo_d;
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_next     = state;
    load_ops       = 1'b0;
    load_res       = 1'b0;
    res_hi_d       = '0;
    res_lo_d       = '0;
    bus.stallreq   = 1'b0;
    bus.busy       = 1'b0;
    bus.mul_start  = 1'b0;
    bus.mul_signed = 1'b0;
    bus.mul_a      = '0;
    bus.mul_b      = '0;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_annul  = 1'b0;
    bus.div_a      = '0;
    bus.div_b      = '0;
    bus.hi_we      = 1'b0;
    bus.hi_wdata   = '0;
    bus.lo_we      = 1'b0;
    bus.lo_wdata   = '0;

    // While reset is held every output stays 0; the register block forces IDLE.
    if (!rst) begin
      bus.busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            case (bus.req_op)
              OP_MTHI: begin
                bus.hi_we    = 1'b1;
                bus.hi_wdata = bus.req_src1;
              end
              OP_MTLO: begin
                bus.lo_we    = 1'b1;
                bus.lo_wdata = bus.req_src1;
              end
              OP_MULT, OP_MULTU: begin
                load_ops     = 1'b1;
                bus.stallreq = 1'b1;
                state_next   = MUL_RUN;
              end
              OP_DIV, OP_DIVU: begin
                load_ops     = 1'b1;
                bus.stallreq = 1'b1;
                if (bus.req_src2 == 32'd0) begin
                  // Divide-by-zero result is known now; the divider is bypassed.
                  load_res   = 1'b1;
                  res_hi_d   = bus.req_src1;
                  res_lo_d   = 32'hFFFF_FFFF;
                  state_next = DONE;
                end else begin
                  state_next = DIV_RUN;
                end
              end
              default: ;  // ops 6/7 are not HI/LO-class: no stall, no write
            endcase
          end
        end

        MUL_RUN: begin
          bus.stallreq   = 1'b1;
          bus.mul_a      = opa_q;
          bus.mul_b      = opb_q;
          bus.mul_signed = sign_q;
          if (bus.flush) begin
            state_next = IDLE;
          end else begin
            // Start is held until the engine answers, so it also covers
            // engines that sample start late.
            bus.mul_start = !bus.mul_ready;
            if (bus.mul_ready) begin
              load_res   = 1'b1;
              res_hi_d   = bus.mul_result[63:32];
              res_lo_d   = bus.mul_result[31:0];
              state_next = DONE;
            end
          end
        end

        DIV_RUN: begin
          bus.stallreq   = 1'b1;
          bus.div_a      = opa_q;
          bus.div_b      = opb_q;
          bus.div_signed = sign_q;
          if (bus.flush) begin
            bus.div_annul = 1'b1;
            state_next    = IDLE;
          end else begin
            bus.div_start = !bus.div_ready;
            if (bus.div_ready) begin
              load_res   = 1'b1;
              res_hi_d   = bus.div_result[63:32];  // remainder
              res_lo_d   = bus.div_result[31:0];   // quotient
              state_next = DONE;
            end
          end
        end

        DONE: begin
          // Stall released here, so EX advances; req_valid still describes
          // the finished instruction and must not be re-accepted.
          bus.hi_we    = !bus.flush;
          bus.lo_we    = !bus.flush;
          bus.hi_wdata = res_hi_q;
          bus.lo_wdata = res_lo_q;
          state_next   = IDLE;
        end

        default: state_next = IDLE;
      endcase
    end
  end

endmodule
